// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline: carries the decoded
// control bundle and datapath operands into EX, with hold, bubble and a bubble counter.
module id_ex_register #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_E,
  input  logic                  flush_E,
  input  logic                  valid_D,
  input  logic                  MemtoReg_D,
  input  logic                  RegDst_D,
  input  logic                  MemWrite_D,
  input  logic                  AluSrc_D,
  input  logic                  Branch_D,
  input  logic                  RegWrite_D,
  input  logic                  Jump_D,
  input  logic [2:0]            AluControl_D,
  input  logic [WIDTH-1:0]      RD1_D,
  input  logic [WIDTH-1:0]      RD2_D,
  input  logic [WIDTH-1:0]      SignImm_D,
  input  logic [WIDTH-1:0]      PCPlus4_D,
  input  logic [REG_ADDR_W-1:0] Rs_D,
  input  logic [REG_ADDR_W-1:0] Rt_D,
  input  logic [REG_ADDR_W-1:0] Rd_D,
  output logic                  MemtoReg_E,
  output logic                  RegDst_E,
  output logic                  MemWrite_E,
  output logic                  AluSrc_E,
  output logic                  Branch_E,
  output logic                  RegWrite_E,
  output logic                  Jump_E,
  output logic [2:0]            AluControl_E,
  output logic [WIDTH-1:0]      RD1_E,
  output logic [WIDTH-1:0]      RD2_E,
  output logic [WIDTH-1:0]      SignImm_E,
  output logic [WIDTH-1:0]      PCPlus4_E,
  output logic [REG_ADDR_W-1:0] Rs_E,
  output logic [REG_ADDR_W-1:0] Rt_E,
  output logic [REG_ADDR_W-1:0] Rd_E,
  output logic                  valid_E,
  output logic [CNT_W-1:0]      bubble_cnt
);

  // Per-edge action. flush_E squashes even a stalled stage (control-hazard
  // squash beats hold); stall_E freezes everything, so _D values (even X)
  // are never sampled; an invalid decode slot becomes a bubble.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } action_e;

  action_e w_action;
  logic    w_cnt_sat;

  logic                  r_memtoreg;
  logic                  r_regdst;
  logic                  r_memwrite;
  logic                  r_alusrc;
  logic                  r_branch;
  logic                  r_regwrite;
  logic                  r_jump;
  logic [2:0]            r_alucontrol;
  logic [WIDTH-1:0]      r_rd1;
  logic [WIDTH-1:0]      r_rd2;
  logic [WIDTH-1:0]      r_signimm;
  logic [WIDTH-1:0]      r_pcplus4;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_bubble_cnt;

  always_comb begin
    w_action = ACT_HOLD;
    if (flush_E) begin
      w_action = ACT_BUBBLE;
    end else if (stall_E) begin
      w_action = ACT_HOLD;
    end else if (!valid_D) begin
      w_action = ACT_BUBBLE;
    end else begin
      w_action = ACT_LOAD;
    end
  end

  assign w_cnt_sat = &r_bubble_cnt;

  // Control bundle and valid flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_memtoreg   <= 1'b0;
      r_regdst     <= 1'b0;
      r_memwrite   <= 1'b0;
      r_alusrc     <= 1'b0;
      r_branch     <= 1'b0;
      r_regwrite   <= 1'b0;
      r_jump       <= 1'b0;
      r_alucontrol <= 3'b000;
      r_valid      <= 1'b0;
    end else begin
      case (w_action)
        ACT_LOAD: begin
          r_memtoreg   <= MemtoReg_D;
          r_regdst     <= RegDst_D;
          r_memwrite   <= MemWrite_D;
          r_alusrc     <= AluSrc_D;
          r_branch     <= Branch_D;
          r_regwrite   <= RegWrite_D;
          r_jump       <= Jump_D;
          r_alucontrol <= AluControl_D;
          r_valid      <= 1'b1;
        end
        ACT_BUBBLE: begin
          r_memtoreg   <= 1'b0;
          r_regdst     <= 1'b0;
          r_memwrite   <= 1'b0;
          r_alusrc     <= 1'b0;
          r_branch     <= 1'b0;
          r_regwrite   <= 1'b0;
          r_jump       <= 1'b0;
          r_alucontrol <= 3'b000;
          r_valid      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath fields; bubbles zero the specifiers so $0 never forwards falsely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_signimm <= '0;
      r_pcplus4 <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else begin
      case (w_action)
        ACT_LOAD: begin
          r_rd1     <= RD1_D;
          r_rd2     <= RD2_D;
          r_signimm <= SignImm_D;
          r_pcplus4 <= PCPlus4_D;
          r_rs      <= Rs_D;
          r_rt      <= Rt_D;
          r_rd      <= Rd_D;
        end
        ACT_BUBBLE: begin
          r_rd1     <= '0;
          r_rd2     <= '0;
          r_signimm <= '0;
          r_pcplus4 <= '0;
          r_rs      <= '0;
          r_rt      <= '0;
          r_rd      <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
    end else if (w_action == ACT_BUBBLE && !w_cnt_sat) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign MemtoReg_E   = r_memtoreg;
  assign RegDst_E     = r_regdst;
  assign MemWrite_E   = r_memwrite;
  assign AluSrc_E     = r_alusrc;
  assign Branch_E     = r_branch;
  assign RegWrite_E   = r_regwrite;
  assign Jump_E       = r_jump;
  assign AluControl_E = r_alucontrol;
  assign RD1_E        = r_rd1;
  assign RD2_E        = r_rd2;
  assign SignImm_E    = r_signimm;
  assign PCPlus4_E    = r_pcplus4;
  assign Rs_E         = r_rs;
  assign Rt_E         = r_rt;
  assign Rd_E         = r_rd;
  assign valid_E      = r_valid;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: reset, pass-through, stall, flush-over-stall,
// invalid decode, counter saturation (CNT_W=4) and asynchronous reset.
module tb_id_ex_register;

  localparam int WIDTH      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  logic                  clk;
  logic                  reset;
  logic                  stall_E, flush_E, valid_D;
  logic                  MemtoReg_D, RegDst_D, MemWrite_D, AluSrc_D, Branch_D, RegWrite_D, Jump_D;
  logic [2:0]            AluControl_D;
  logic [WIDTH-1:0]      RD1_D, RD2_D, SignImm_D, PCPlus4_D;
  logic [REG_ADDR_W-1:0] Rs_D, Rt_D, Rd_D;
  logic                  MemtoReg_E, RegDst_E, MemWrite_E, AluSrc_E, Branch_E, RegWrite_E, Jump_E;
  logic [2:0]            AluControl_E;
  logic [WIDTH-1:0]      RD1_E, RD2_E, SignImm_E, PCPlus4_E;
  logic [REG_ADDR_W-1:0] Rs_E, Rt_E, Rd_E;
  logic                  valid_E;
  logic [CNT_W-1:0]      bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_register #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
    .MemtoReg_D(MemtoReg_D), .RegDst_D(RegDst_D), .MemWrite_D(MemWrite_D),
    .AluSrc_D(AluSrc_D), .Branch_D(Branch_D), .RegWrite_D(RegWrite_D), .Jump_D(Jump_D),
    .AluControl_D(AluControl_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .PCPlus4_D(PCPlus4_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .MemtoReg_E(MemtoReg_E), .RegDst_E(RegDst_E), .MemWrite_E(MemWrite_E),
    .AluSrc_E(AluSrc_E), .Branch_E(Branch_E), .RegWrite_E(RegWrite_E), .Jump_E(Jump_E),
    .AluControl_E(AluControl_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E),
    .PCPlus4_E(PCPlus4_E), .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
    .valid_E(valid_E), .bubble_cnt(bubble_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge and sample 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic vld, input logic [6:0] ctl, input logic [2:0] alu,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc4,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    valid_D = vld;
    {MemtoReg_D, RegDst_D, MemWrite_D, AluSrc_D, Branch_D, RegWrite_D, Jump_D} = ctl;
    AluControl_D = alu;
    RD1_D = rd1; RD2_D = rd2; SignImm_D = imm; PCPlus4_D = pc4;
    Rs_D = rs; Rt_D = rt; Rd_D = rd;
  endtask

  function automatic logic [6:0] ctl_e();
    return {MemtoReg_E, RegDst_E, MemWrite_E, AluSrc_E, Branch_E, RegWrite_E, Jump_E};
  endfunction

  initial begin
    reset = 1'b0; stall_E = 1'b0; flush_E = 1'b0;
    drive_d(1'b1, 7'h7F, 3'b111, '1, '1, '1, '1, 5'h1F, 5'h1F, 5'h1F);

    // edges while reset is low must not capture
    step();
    step();
    check("rst_ctl", 32'(ctl_e()), 32'h0);
    check("rst_rd1", RD1_E, 32'h0);
    check("rst_pc4", PCPlus4_E, 32'h0);
    check("rst_rd", 32'(Rd_E), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rel_valid", 32'(valid_E), 32'h0);
    check("rst_rel_cnt", 32'(bubble_cnt), 32'h0);
    check("rst_rel_alu", 32'(AluControl_E), 32'h0);

    // pass-through
    drive_d(1'b1, 7'b0000010, 3'b010, 32'h5, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    step();
    check("pt_regwrite", 32'(RegWrite_E), 32'h1);
    check("pt_alu", 32'(AluControl_E), 32'h2);
    check("pt_rd1", RD1_E, 32'h5);
    check("pt_rt", 32'(Rt_E), 32'd9);
    check("pt_valid", 32'(valid_E), 32'h1);
    check("pt_cnt", 32'(bubble_cnt), 32'h0);

    // stall: load A, then hold for 3 edges while _D changes (including X)
    drive_d(1'b1, 7'b1010101, 3'b110, 32'hA1A1_0001, 32'hA2A2_0002, 32'hFFFF_FFF0,
            32'h0040_0010, 5'd3, 5'd4, 5'd5);
    step();
    check("a_ctl", 32'(ctl_e()), 32'h55);
    check("a_imm", SignImm_E, 32'hFFFF_FFF0);
    stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_d(1'b1, 7'b0101010, 3'(i), 32'hB000_0000 + 32'(i), 32'hx, 32'h1234,
              32'h0040_0100, 5'd20, 5'd21, 5'd22);
      if (i == 2) valid_D = 1'b0;
      step();
      check("stall_rd1", RD1_E, 32'hA1A1_0001);
      check("stall_rd2", RD2_E, 32'hA2A2_0002);
      check("stall_ctl", 32'(ctl_e()), 32'h55);
    end
    check("stall_rs", 32'(Rs_E), 32'd3);
    check("stall_pc4", PCPlus4_E, 32'h0040_0010);
    check("stall_cnt", 32'(bubble_cnt), 32'h0);
    stall_E = 1'b0;
    drive_d(1'b1, 7'b0100011, 3'b001, 32'hC0DE_0001, 32'hC0DE_0002, 32'h8,
            32'h0040_0020, 5'd6, 5'd7, 5'd8);
    step();
    check("unstall_rd1", RD1_E, 32'hC0DE_0001);
    check("unstall_ctl", 32'(ctl_e()), 32'h23);
    check("unstall_rd", 32'(Rd_E), 32'd8);

    // flush wins over stall
    flush_E = 1'b1; stall_E = 1'b1;
    drive_d(1'b1, 7'b0010000, 3'b011, 32'h77, 32'h88, 32'h99, 32'hAA, 5'd7, 5'd8, 5'd9);
    step();
    check("fl_memwrite", 32'(MemWrite_E), 32'h0);
    check("fl_valid", 32'(valid_E), 32'h0);
    check("fl_rs", 32'(Rs_E), 32'h0);
    check("fl_rd1", RD1_E, 32'h0);
    check("fl_alu", 32'(AluControl_E), 32'h0);
    check("fl_cnt", 32'(bubble_cnt), 32'h1);

    // invalid decode for 2 edges
    flush_E = 1'b0; stall_E = 1'b0;
    drive_d(1'b0, 7'b0000010, 3'b010, 32'h11, 32'h22, 32'h33, 32'h44, 5'd1, 5'd2, 5'd3);
    step();
    step();
    check("inv_regwrite", 32'(RegWrite_E), 32'h0);
    check("inv_valid", 32'(valid_E), 32'h0);
    check("inv_rt", 32'(Rt_E), 32'h0);
    check("inv_cnt", 32'(bubble_cnt), 32'h3);

    // stall with invalid decode does not count a bubble
    stall_E = 1'b1;
    step();
    check("stall_inv_cnt", 32'(bubble_cnt), 32'h3);
    stall_E = 1'b0;

    // saturation: 20 flush edges starting from 3
    flush_E = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 11) check("sat_14", 32'(bubble_cnt), 32'hE);
      if (i == 12) check("sat_15", 32'(bubble_cnt), 32'hF);
    end
    check("sat_hold", 32'(bubble_cnt), 32'hF);
    flush_E = 1'b0;

    // a LOAD does not touch the saturated counter
    drive_d(1'b1, 7'b1000001, 3'b100, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h0040_0030,
            5'd10, 5'd11, 5'd12);
    step();
    check("ld_cnt", 32'(bubble_cnt), 32'hF);
    check("ld_rd1", RD1_E, 32'hDEAD_BEEF);
    check("ld_valid", 32'(valid_E), 32'h1);

    // asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    check("arst_cnt", 32'(bubble_cnt), 32'h0);
    check("arst_valid", 32'(valid_E), 32'h0);
    check("arst_rd1", RD1_E, 32'h0);
    check("arst_ctl", 32'(ctl_e()), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // first capture after reset release
    drive_d(1'b1, 7'b0001000, 3'b101, 32'h0000_1234, 32'h0, 32'h4, 32'h0040_0040,
            5'd13, 5'd14, 5'd15);
    step();
    check("post_rd1", RD1_E, 32'h0000_1234);
    check("post_ctl", 32'(ctl_e()), 32'h08);
    check("post_cnt", 32'(bubble_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
